exec_alu_cluster: RTL and testbench

- Execute stage directly downstream of the issue queue. Consumes the ISSUE_W ALU issue lanes and produces the CDB broadcasts (tag + value) that the issue queue snoops for wakeup.
- Single-cycle logical/arithmetic ops and a pipelined multiplier per lane.
- Per-lane result FIFO absorbs writeback collisions. Stall feedback goes to issue select.

---
 rtl/exec_alu_cluster_pkg.sv | 44 ++++
 rtl/exec_result_fifo.sv | 65 ++++++
 rtl/exec_alu_cluster.sv | 126 ++++++++++++
 tb/tb_exec_alu_cluster.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_alu_cluster_pkg.sv
// Shared types and constants for the ALU execute cluster: opcode encoding,
// result record, multiplier latency, result FIFO depth and the ALU evaluator.
package exec_alu_cluster_pkg;

  localparam int ISSUE_WIDTH     = 2;
  localparam int PREGS           = 64;
  localparam int PHYS_TAG_W      = $clog2(PREGS);
  localparam int ROB_W           = 5;
  localparam int MUL_LAT         = 3;
  localparam int EXEC_FIFO_DEPTH = 4;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5
  } alu_op_t;

  typedef struct packed {
    logic [PHYS_TAG_W-1:0] tag;
    logic [ROB_W-1:0]      rob;
    logic [31:0]           value;
  } exec_result_t;

  // Unknown opcodes still produce a broadcast, carrying a zero value.
  function automatic logic [31:0] alu_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_MUL: r = a * b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_result_fifo.sv
// Per-lane result FIFO: two ordered pushes (A older than B) and one pop per
// cycle; the count separates full from empty since pointers wrap.
module exec_result_fifo
  import exec_alu_cluster_pkg::*;
#(
  parameter int DEPTH = EXEC_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_a_i,
  input  exec_result_t     data_a_i,
  input  logic             push_b_i,
  input  exec_result_t     data_b_i,
  input  logic             pop_i,
  output exec_result_t     head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  exec_result_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_b_s;
  logic [CNT_W-1:0] count_q, count_d, cnt_after_a_s;
  logic             acc_a_s, acc_b_s, do_pop_s;

  // Room is judged on the occupancy before this cycle's pop.
  always_comb begin
    acc_a_s       = push_a_i && (count_q < DEPTH_C);
    cnt_after_a_s = count_q + CNT_W'(acc_a_s);
    acc_b_s       = push_b_i && (cnt_after_a_s < DEPTH_C);
    do_pop_s      = pop_i && (count_q != '0);
    wr_ptr_b_s    = wr_ptr_q + PTR_W'(acc_a_s);
    wr_ptr_d      = wr_ptr_b_s + PTR_W'(acc_b_s);
    rd_ptr_d      = rd_ptr_q + PTR_W'(do_pop_s);
    count_d       = cnt_after_a_s + CNT_W'(acc_b_s) - CNT_W'(do_pop_s);
    drop_o        = (push_a_i && !acc_a_s) || (push_b_i && !acc_b_s);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc_a_s) mem_q[wr_ptr_q] <= data_a_i;
    if (acc_b_s) mem_q[wr_ptr_b_s] <= data_b_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/exec_alu_cluster.sv
// ALU execute cluster: per-lane single-cycle ALU, MUL pipe and result FIFO
// feeding the CDB. Define EXEC_PERF_CNT_EN to add per-lane perf counters.
module exec_alu_cluster
  import exec_alu_cluster_pkg::*;
#(
  parameter int ISSUE_W    = ISSUE_WIDTH,
  parameter int TAG_W      = PHYS_TAG_W,
  parameter int MUL_LAT    = exec_alu_cluster_pkg::MUL_LAT,
  parameter int FIFO_DEPTH = EXEC_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ISSUE_W-1:0]            issue_valid,
  input  logic [ISSUE_W-1:0][3:0]       issue_opcode,
  input  logic [ISSUE_W-1:0][31:0]      issue_src1_val,
  input  logic [ISSUE_W-1:0][31:0]      issue_src2_val,
  input  logic [ISSUE_W-1:0][TAG_W-1:0] issue_dst_phys,
  input  logic [ISSUE_W-1:0][4:0]       issue_dst_rob,
  input  logic                          flush,
  output logic [ISSUE_W-1:0]            lane_stall,
  output logic [ISSUE_W-1:0]            cdb_valid,
  output logic [ISSUE_W-1:0][TAG_W-1:0] cdb_tag,
  output logic [ISSUE_W-1:0][31:0]      cdb_value,
  output logic [ISSUE_W-1:0][4:0]       cdb_rob,
  output logic                          overflow_err
`ifdef EXEC_PERF_CNT_EN
  ,
  output logic [ISSUE_W-1:0][31:0]      perf_ops,
  output logic [ISSUE_W-1:0][31:0]      perf_coll
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic               kill_s;
  logic [ISSUE_W-1:0] drop_vec_s;
  logic               overflow_q;

  assign kill_s = reset || flush;

  for (genvar l = 0; l < ISSUE_W; l++) begin : g_lane
    logic               issue_ok_s, issue_mul_s, issue_alu_s, push_mul_s;
    exec_result_t       res_s, head_s;
    logic [MUL_LAT-2:0] mul_vld_q;
    exec_result_t       mul_res_q [MUL_LAT-1];
    logic [CNT_W-1:0]   count_s;
    logic               head_vld_s, drop_s;
    int                 slack_s;

    // Decode the issue slot; nothing is accepted in a reset or flush cycle.
    always_comb begin
      issue_ok_s  = issue_valid[l] && !kill_s;
      issue_mul_s = issue_ok_s && (issue_opcode[l] == ALU_MUL);
      issue_alu_s = issue_ok_s && (issue_opcode[l] != ALU_MUL);
      res_s.tag   = issue_dst_phys[l];
      res_s.rob   = issue_dst_rob[l];
      res_s.value = alu_result(issue_opcode[l], issue_src1_val[l], issue_src2_val[l]);
      push_mul_s  = mul_vld_q[MUL_LAT-2] && !kill_s;
      slack_s     = FIFO_DEPTH - int'(count_s) - $countones(mul_vld_q);
    end

    // The product is formed at issue and carried down the pipe.
    always_ff @(posedge clk) begin
      mul_res_q[0] <= res_s;
      for (int s = 1; s < MUL_LAT - 1; s++) mul_res_q[s] <= mul_res_q[s-1];
      if (kill_s) begin
        mul_vld_q <= '0;
      end else begin
        mul_vld_q[0] <= issue_mul_s;
        for (int s = 1; s < MUL_LAT - 1; s++) mul_vld_q[s] <= mul_vld_q[s-1];
      end
    end

    exec_result_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk_i    (clk),
      .reset_i  (reset),
      .flush_i  (flush),
      .push_a_i (push_mul_s),
      .data_a_i (mul_res_q[MUL_LAT-2]),
      .push_b_i (issue_alu_s),
      .data_b_i (res_s),
      .pop_i    (head_vld_s),
      .head_o   (head_s),
      .valid_o  (head_vld_s),
      .count_o  (count_s),
      .drop_o   (drop_s)
    );

    assign cdb_valid[l]  = head_vld_s;
    assign cdb_tag[l]    = head_s.tag;
    assign cdb_value[l]  = head_s.value;
    assign cdb_rob[l]    = head_s.rob;
    assign lane_stall[l] = (slack_s < 2);
    assign drop_vec_s[l] = drop_s;

`ifdef EXEC_PERF_CNT_EN
    logic [31:0] ops_q, coll_q;

    // Saturating per-lane activity counters, untouched by flush.
    always_ff @(posedge clk) begin
      if (reset) begin
        ops_q  <= 32'd0;
        coll_q <= 32'd0;
      end else begin
        if (issue_ok_s && (ops_q != 32'hFFFF_FFFF)) ops_q <= ops_q + 32'd1;
        if (push_mul_s && issue_alu_s && (coll_q != 32'hFFFF_FFFF)) coll_q <= coll_q + 32'd1;
      end
    end

    assign perf_ops[l]  = ops_q;
    assign perf_coll[l] = coll_q;
`endif
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (|drop_vec_s) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_exec_alu_cluster.sv
// Bench for exec_alu_cluster: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a shallow-FIFO instance.
module tb_exec_alu_cluster;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  typedef struct {
    logic [5:0]  tag;
    logic [4:0]  rob;
    logic [31:0] value;
    int          rem;
  } res_t;

  logic             clk = 1'b0;
  logic             reset, flush;
  logic [1:0]       issue_valid;
  logic [1:0][3:0]  issue_opcode;
  logic [1:0][31:0] issue_src1_val, issue_src2_val;
  logic [1:0][5:0]  issue_dst_phys;
  logic [1:0][4:0]  issue_dst_rob;
  logic [1:0]       lane_stall, cdb_valid;
  logic [1:0][5:0]  cdb_tag;
  logic [1:0][31:0] cdb_value;
  logic [1:0][4:0]  cdb_rob;
  logic             overflow_err;

  logic             o_reset, o_flush;
  logic [1:0]       o_valid;
  logic [1:0][3:0]  o_opcode;
  logic [1:0][31:0] o_src1, o_src2;
  logic [1:0][5:0]  o_phys;
  logic [1:0][4:0]  o_rob;
  logic [1:0]       o_lane_stall, o_cdb_valid;
  logic [1:0][5:0]  o_cdb_tag;
  logic [1:0][31:0] o_cdb_value;
  logic [1:0][4:0]  o_cdb_rob;
  logic             o_overflow_err;

  res_t fq [2][$];
  res_t mq [2][$];
  bit   m_ovf;
  bit   inited;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  exec_alu_cluster dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_src1_val(issue_src1_val), .issue_src2_val(issue_src2_val),
    .issue_dst_phys(issue_dst_phys), .issue_dst_rob(issue_dst_rob), .flush(flush),
    .lane_stall(lane_stall), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_rob(cdb_rob), .overflow_err(overflow_err)
  );

  // Two-entry FIFO so that a full FIFO can actually be hit.
  exec_alu_cluster #(.FIFO_DEPTH(2)) dut_ovf (
    .clk(clk), .reset(o_reset), .issue_valid(o_valid), .issue_opcode(o_opcode),
    .issue_src1_val(o_src1), .issue_src2_val(o_src2),
    .issue_dst_phys(o_phys), .issue_dst_rob(o_rob), .flush(o_flush),
    .lane_stall(o_lane_stall), .cdb_valid(o_cdb_valid), .cdb_tag(o_cdb_tag),
    .cdb_value(o_cdb_value), .cdb_rob(o_cdb_rob), .overflow_err(o_overflow_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_val(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_stall(input int l);
    return ((DEPTH - fq[l].size()) - mq[l].size()) < 2;
  endfunction

  task automatic compare();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("valid%0d", l), 32'(cdb_valid[l]), 32'(fq[l].size() > 0));
      chk($sformatf("stall%0d", l), 32'(lane_stall[l]), 32'(model_stall(l)));
      if (fq[l].size() > 0) begin
        chk($sformatf("tag%0d", l), 32'(cdb_tag[l]), 32'(fq[l][0].tag));
        chk($sformatf("rob%0d", l), 32'(cdb_rob[l]), 32'(fq[l][0].rob));
        chk($sformatf("value%0d", l), cdb_value[l], fq[l][0].value);
      end
    end
    chk("overflow", 32'(overflow_err), 32'(m_ovf));
  endtask

  task automatic model_update();
    res_t pushes[$];
    res_t keep[$];
    res_t r;
    int   sz0;
    int   acc;
    if (reset) begin
      for (int l = 0; l < 2; l++) begin fq[l].delete(); mq[l].delete(); end
      m_ovf = 1'b0;
    end else if (flush) begin
      for (int l = 0; l < 2; l++) begin fq[l].delete(); mq[l].delete(); end
    end else begin
      for (int l = 0; l < 2; l++) begin
        pushes.delete();
        keep.delete();
        for (int k = 0; k < mq[l].size(); k++) begin
          r = mq[l][k];
          if (r.rem == 1) pushes.push_back(r);
          else begin r.rem--; keep.push_back(r); end
        end
        mq[l] = keep;
        if (issue_valid[l]) begin
          r.tag   = issue_dst_phys[l];
          r.rob   = issue_dst_rob[l];
          r.value = ref_val(int'(issue_opcode[l]), issue_src1_val[l], issue_src2_val[l]);
          r.rem   = LAT - 1;
          if (issue_opcode[l] == 4'd2) mq[l].push_back(r);
          else pushes.push_back(r);
        end
        sz0 = fq[l].size();
        acc = 0;
        keep.delete();
        for (int k = 0; k < pushes.size(); k++) begin
          if (sz0 + acc < DEPTH) begin keep.push_back(pushes[k]); acc++; end
          else m_ovf = 1'b1;
        end
        if (sz0 > 0) void'(fq[l].pop_front());
        for (int k = 0; k < keep.size(); k++) fq[l].push_back(keep[k]);
      end
    end
  endtask

  // Called at a falling edge: check outputs, advance the model, wait one cycle.
  task automatic step();
    if (inited) compare();
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 2'b00; flush = 1'b0; reset = 1'b0;
    o_valid = 2'b00; o_flush = 1'b0; o_reset = 1'b0;
  endtask

  task automatic set_issue(input int l, input int op, input logic [31:0] a, input logic [31:0] b,
                           input int tag, input int rob);
    issue_valid[l] = 1'b1; issue_opcode[l] = 4'(op);
    issue_src1_val[l] = a; issue_src2_val[l] = b;
    issue_dst_phys[l] = 6'(tag); issue_dst_rob[l] = 5'(rob);
  endtask

  task automatic set_ovf(input int op, input logic [31:0] a, input logic [31:0] b, input int tag);
    o_valid[0] = 1'b1; o_opcode[0] = 4'(op); o_src1[0] = a; o_src2[0] = b;
    o_phys[0] = 6'(tag); o_rob[0] = 5'(tag);
  endtask

  initial begin
    inited = 1'b0;
    m_ovf = 1'b0;
    issue_opcode = '0; issue_src1_val = '0; issue_src2_val = '0;
    issue_dst_phys = '0; issue_dst_rob = '0;
    o_opcode = '0; o_src1 = '0; o_src2 = '0; o_phys = '0; o_rob = '0;
    idle();
    reset = 1'b1; o_reset = 1'b1;
    step();
    step();
    idle();
    inited = 1'b1;
    chk("reset_valid", 32'(cdb_valid), 32'h0);
    chk("reset_stall", 32'(lane_stall), 32'h0);
    chk("reset_ovf", 32'(overflow_err), 32'h0);

    // ADD 5+3 -> p10, rob 0
    set_issue(0, 0, 32'd5, 32'd3, 10, 0); step(); idle();
    chk("add_valid", 32'(cdb_valid), 32'h1);
    chk("add_tag", 32'(cdb_tag[0]), 32'd10);
    chk("add_value", cdb_value[0], 32'd8);
    chk("add_rob", 32'(cdb_rob[0]), 32'd0);
    step(); step();

    // MUL 8*7 -> p11, visible three cycles later
    set_issue(0, 2, 32'd8, 32'd7, 11, 1); step(); idle();
    chk("mul_c2_valid", 32'(cdb_valid), 32'h0);
    step();
    chk("mul_c3_valid", 32'(cdb_valid), 32'h0);
    step();
    chk("mul_c4_valid", 32'(cdb_valid), 32'h1);
    chk("mul_c4_value", cdb_value[0], 32'd56);
    step(); step();

    // MUL then SUB colliding in lane 0
    set_issue(0, 2, 32'd4, 32'd4, 20, 2); step(); idle();
    step();
    set_issue(0, 1, 32'd9, 32'd2, 21, 3); step(); idle();
    chk("coll_c4_tag", 32'(cdb_tag[0]), 32'd20);
    chk("coll_c4_value", cdb_value[0], 32'd16);
    chk("coll_c4_stall", 32'(lane_stall[0]), 32'h0);
    step();
    chk("coll_c5_tag", 32'(cdb_tag[0]), 32'd21);
    chk("coll_c5_value", cdb_value[0], 32'd7);
    step(); step();

    // Both lanes in the same cycle
    set_issue(0, 5, 32'hF0, 32'hFF, 5, 4);
    set_issue(1, 1, 32'd0, 32'd1, 6, 5);
    step(); idle();
    chk("dual_valid", 32'(cdb_valid), 32'h3);
    chk("dual_xor", cdb_value[0], 32'h0000_000F);
    chk("dual_sub", cdb_value[1], 32'hFFFF_FFFF);
    step(); step();

    // Flush with a MUL in flight and two entries queued
    set_issue(0, 2, 32'd3, 32'd3, 30, 6); step(); idle();
    set_issue(0, 2, 32'd5, 32'd5, 31, 7); step(); idle();
    set_issue(0, 0, 32'd1, 32'd1, 32, 8); step(); idle();
    chk("preflush_valid", 32'(cdb_valid[0]), 32'h1);
    flush = 1'b1; step(); idle();
    for (int k = 0; k < 4; k++) begin
      chk("postflush_valid", 32'(cdb_valid), 32'h0);
      step();
    end

    // Shallow instance: fill, drop, stay sticky through flush, clear on reset
    set_ovf(2, 32'd3, 32'd5, 1); step(); idle();
    set_ovf(2, 32'd2, 32'd2, 2); step(); idle();
    set_ovf(0, 32'd1, 32'd1, 3); step(); idle();
    chk("ovf_pre_flag", 32'(o_overflow_err), 32'h0);
    chk("ovf_pre_value", o_cdb_value[0], 32'd15);
    chk("ovf_pre_stall", 32'(o_lane_stall[0]), 32'h1);
    set_ovf(0, 32'd4, 32'd4, 4); step(); idle();
    chk("ovf_flag", 32'(o_overflow_err), 32'h1);
    chk("ovf_head_tag", 32'(o_cdb_tag[0]), 32'd3);
    chk("ovf_head_rob", 32'(o_cdb_rob[0]), 32'd3);
    chk("ovf_head_value", o_cdb_value[0], 32'd2);
    o_flush = 1'b1; step(); idle();
    chk("ovf_flush_valid", 32'(o_cdb_valid), 32'h0);
    chk("ovf_after_flush", 32'(o_overflow_err), 32'h1);
    step(); step();
    chk("ovf_held", 32'(o_overflow_err), 32'h1);
    o_reset = 1'b1; step(); idle();
    chk("ovf_reset", 32'(o_overflow_err), 32'h0);

    // Randomized traffic honouring lane_stall
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      reset = (cyc == 200);
      flush = ($urandom_range(0, 39) == 0);
      for (int l = 0; l < 2; l++) begin
        if (!model_stall(l) && $urandom_range(0, 3) != 0) begin
          set_issue(l, int'($urandom_range(0, 7)),
                    ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : 32'($urandom),
                    32'($urandom),
                    int'($urandom_range(0, 63)), int'($urandom_range(0, 31)));
        end
      end
      step();
    end
    idle();
    for (int k = 0; k < 8; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
